// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter that shares one dcache port among NUM_CONSUMERS LSUs.
// Both sides use a 4-phase valid/ready handshake; one request is in flight at a time.
module dcache_port_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CONSUMERS-1:0]         consumer_read_valid,
  input  logic [ADDR_BITS-1:0]             consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]         consumer_read_ready,
  output logic [DATA_BITS-1:0]             consumer_read_data     [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0]         consumer_write_valid,
  input  logic [ADDR_BITS-1:0]             consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]             consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]         consumer_write_ready,
  output logic                             cache_read_valid,
  output logic [ADDR_BITS-1:0]             cache_read_address,
  input  logic                             cache_read_ready,
  input  logic [DATA_BITS-1:0]             cache_read_data,
  output logic                             cache_write_valid,
  output logic [ADDR_BITS-1:0]             cache_write_address,
  output logic [DATA_BITS-1:0]             cache_write_data,
  input  logic                             cache_write_ready,
  output logic [$clog2(NUM_CONSUMERS)-1:0] grant_id,
  output logic                             busy
);

  localparam int ID_W = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELEASE
  } state_t;

  state_t                     state_q, state_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic                       is_write_q, is_write_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic [DATA_BITS-1:0]       wdata_q, wdata_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       wr_valid_q, wr_valid_d;
  logic [NUM_CONSUMERS-1:0]   rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0]   wr_ready_q, wr_ready_d;
  logic [DATA_BITS-1:0]       rdata_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]       rdata_d [NUM_CONSUMERS];

  logic [NUM_CONSUMERS-1:0]   req;
  logic                       found;
  logic [ID_W-1:0]            win;
  logic [ID_W:0]              sum;
  logic                       release_ok;

  assign req = consumer_read_valid | consumer_write_valid;

  // Rotating search from rr_ptr; the extra sum bit keeps the modulo exact for
  // non-power-of-two consumer counts.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(NUM_CONSUMERS)) begin
        sum = sum - (ID_W + 1)'(NUM_CONSUMERS);
      end
      if (!found && req[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    if (is_write_q) begin
      release_ok = !consumer_write_valid[id_q] && !cache_write_ready;
    end else begin
      release_ok = !consumer_read_valid[id_q] && !cache_read_ready;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    rd_ready_d = rd_ready_q;
    wr_ready_d = wr_ready_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d = win;
          if (consumer_read_valid[win]) begin
            is_write_d = 1'b0;
            addr_d     = consumer_read_address[win];
            rd_valid_d = 1'b1;
            state_d    = READ_WAIT;
          end else begin
            is_write_d = 1'b1;
            addr_d     = consumer_write_address[win];
            wdata_d    = consumer_write_data[win];
            wr_valid_d = 1'b1;
            state_d    = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (cache_read_ready) begin
          rd_valid_d       = 1'b0;
          rdata_d[id_q]    = cache_read_data;
          rd_ready_d[id_q] = 1'b1;
          state_d          = RELEASE;
        end
      end
      WRITE_WAIT: begin
        if (cache_write_ready) begin
          wr_valid_d       = 1'b0;
          wr_ready_d[id_q] = 1'b1;
          state_d          = RELEASE;
        end
      end
      RELEASE: begin
        if (release_ok) begin
          rd_ready_d = '0;
          wr_ready_d = '0;
          rr_ptr_d   = (id_q == ID_W'(NUM_CONSUMERS - 1)) ? '0 : id_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rdata_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rdata_q    <= rdata_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign consumer_read_data   = rdata_q;
  assign cache_read_valid     = rd_valid_q;
  assign cache_read_address   = addr_q;
  assign cache_write_valid    = wr_valid_q;
  assign cache_write_address  = addr_q;
  assign cache_write_data     = wdata_q;
  assign grant_id             = id_q;
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: directed LSU traffic against a
// behavioural dcache; a monitor pops expected requests/responses as they appear.
`timescale 1ns/1ps
module tb_dcache_port_arbiter;

  localparam int N   = 8;
  localparam int TMO = 500;

  typedef struct {
    int         id;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] consumer_read_valid;
  logic [7:0]   consumer_read_address [N];
  logic [N-1:0] consumer_read_ready;
  logic [7:0]   consumer_read_data [N];
  logic [N-1:0] consumer_write_valid;
  logic [7:0]   consumer_write_address [N];
  logic [7:0]   consumer_write_data [N];
  logic [N-1:0] consumer_write_ready;
  logic         cache_read_valid;
  logic [7:0]   cache_read_address;
  logic         cache_read_ready;
  logic [7:0]   cache_read_data;
  logic         cache_write_valid;
  logic [7:0]   cache_write_address;
  logic [7:0]   cache_write_data;
  logic         cache_write_ready;
  logic [2:0]   grant_id;
  logic         busy;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   lsu_done  = 0;
  int   cache_lat = 1;
  txn_t req_q[$];
  txn_t rsp_q[$];

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .ADDR_BITS    (8),
    .DATA_BITS    (8),
    .NUM_CONSUMERS(N)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .consumer_write_valid  (consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data   (consumer_write_data),
    .consumer_write_ready  (consumer_write_ready),
    .cache_read_valid      (cache_read_valid),
    .cache_read_address    (cache_read_address),
    .cache_read_ready      (cache_read_ready),
    .cache_read_data       (cache_read_data),
    .cache_write_valid     (cache_write_valid),
    .cache_write_address   (cache_write_address),
    .cache_write_data      (cache_write_data),
    .cache_write_ready     (cache_write_ready),
    .grant_id              (grant_id),
    .busy                  (busy)
  );

  function automatic logic [7:0] mem_rd(input logic [7:0] a);
    return a ^ 8'h76;
  endfunction

  function automatic txn_t mk(input int id, input bit wr, input logic [7:0] addr,
                              input logic [7:0] data);
    txn_t t;
    t.id = id; t.wr = wr; t.addr = addr; t.data = data;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int id);
    n_checks++;
    n_fail++;
    $display("FAIL %s: consumer %0d timed out after %0d cycles", name, id, TMO);
  endtask

  task automatic expect_rd(input int id, input logic [7:0] addr, input logic [7:0] data);
    req_q.push_back(mk(id, 1'b0, addr, 8'h00));
    rsp_q.push_back(mk(id, 1'b0, addr, data));
  endtask

  task automatic expect_wr(input int id, input logic [7:0] addr, input logic [7:0] data);
    req_q.push_back(mk(id, 1'b1, addr, data));
    rsp_q.push_back(mk(id, 1'b1, addr, 8'h00));
  endtask

  task automatic lsu_read(input int id, input logic [7:0] addr, input int hold);
    int t;
    consumer_read_address[id] = addr;
    consumer_read_valid[id]   = 1'b1;
    t = 0;
    while (!consumer_read_ready[id] && t < TMO) begin @(negedge clk); t++; end
    if (!consumer_read_ready[id]) timeout_fail("lsu_read_ready", id);
    repeat (hold) @(negedge clk);
    consumer_read_valid[id] = 1'b0;
    t = 0;
    while (consumer_read_ready[id] && t < TMO) begin @(negedge clk); t++; end
    lsu_done++;
  endtask

  task automatic lsu_write(input int id, input logic [7:0] addr, input logic [7:0] data,
                           input int hold);
    int t;
    consumer_write_address[id] = addr;
    consumer_write_data[id]    = data;
    consumer_write_valid[id]   = 1'b1;
    t = 0;
    while (!consumer_write_ready[id] && t < TMO) begin @(negedge clk); t++; end
    if (!consumer_write_ready[id]) timeout_fail("lsu_write_ready", id);
    repeat (hold) @(negedge clk);
    consumer_write_valid[id] = 1'b0;
    t = 0;
    while (consumer_write_ready[id] && t < TMO) begin @(negedge clk); t++; end
    lsu_done++;
  endtask

  task automatic wait_done(input string name, input int target);
    int t;
    t = 0;
    while (lsu_done < target && t < 4 * TMO) begin @(negedge clk); t++; end
    check(name, 32'(lsu_done), 32'(target));
  endtask

  task automatic wait_read_ready(input string name, input int id);
    int t;
    t = 0;
    while (!consumer_read_ready[id] && t < TMO) begin @(negedge clk); t++; end
    if (!consumer_read_ready[id]) timeout_fail(name, id);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < TMO) begin @(negedge clk); t++; end
    if (busy) timeout_fail("wait_idle", 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_dut();
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cache_rd_valid", 32'(cache_read_valid), 32'd0);
    check("rst_cache_wr_valid", 32'(cache_write_valid), 32'd0);
    check("rst_cache_addr", 32'({cache_read_address, cache_write_address}), 32'd0);
    check("rst_cache_wdata", 32'(cache_write_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_ready", 32'({consumer_read_ready, consumer_write_ready}), 32'd0);
    for (int i = 0; i < N; i++) check("rst_rd_data", 32'(consumer_read_data[i]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Behavioural dcache: ready after cache_lat cycles of valid, held until valid drops.
  initial begin
    int k;
    cache_read_ready = 1'b0;
    cache_read_data  = '0;
    forever begin
      @(negedge clk);
      if (cache_read_valid && !cache_read_ready) begin
        k = 1;
        while (k < cache_lat && cache_read_valid) begin @(negedge clk); k++; end
        if (cache_read_valid) begin
          cache_read_data  = mem_rd(cache_read_address);
          cache_read_ready = 1'b1;
          while (cache_read_valid) @(negedge clk);
          cache_read_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    int k;
    cache_write_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (cache_write_valid && !cache_write_ready) begin
        k = 1;
        while (k < cache_lat && cache_write_valid) begin @(negedge clk); k++; end
        if (cache_write_valid) begin
          cache_write_ready = 1'b1;
          while (cache_write_valid) @(negedge clk);
          cache_write_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every new cache request and every new consumer response.
  initial begin
    logic         prv_crv, prv_cwv;
    logic [N-1:0] prv_rr, prv_wr;
    logic [31:0]  act, exp;
    txn_t         e;
    prv_crv = 1'b0; prv_cwv = 1'b0; prv_rr = '0; prv_wr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("excl_valid_ready",
              32'({(cache_read_valid && cache_write_valid),
                   !$onehot0({consumer_read_ready, consumer_write_ready})}), 32'd0);
        if ((cache_read_valid && !prv_crv) || (cache_write_valid && !prv_cwv)) begin
          act = 32'({cache_write_valid, grant_id,
                     cache_write_valid ? cache_write_address : cache_read_address,
                     cache_write_valid ? cache_write_data : 8'h00});
          if (req_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL req_unexpected: actual=0x%0h required=none", act);
          end else begin
            e   = req_q.pop_front();
            exp = 32'({e.wr, 3'(e.id), e.addr, e.wr ? e.data : 8'h00});
            check("req{wr,id,addr,wdata}", act, exp);
          end
        end
        for (int i = 0; i < N; i++) begin
          if ((consumer_read_ready[i] && !prv_rr[i]) || (consumer_write_ready[i] && !prv_wr[i])) begin
            act = 32'({consumer_write_ready[i], 3'(i),
                       consumer_write_ready[i] ? 8'h00 : consumer_read_data[i]});
            if (rsp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL rsp_unexpected: actual=0x%0h required=none", act);
            end else begin
              e   = rsp_q.pop_front();
              exp = 32'({e.wr, 3'(e.id), e.data});
              check("rsp{wr,id,rdata}", act, exp);
            end
          end
        end
      end
      prv_crv = cache_read_valid;
      prv_cwv = cache_write_valid;
      prv_rr  = consumer_read_ready;
      prv_wr  = consumer_write_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset                = 1'b0;
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    for (int i = 0; i < N; i++) begin
      consumer_read_address[i]  = '0;
      consumer_write_address[i] = '0;
      consumer_write_data[i]    = '0;
    end

    // 1: single read, address changes after grant are ignored
    reset_dut();
    cache_lat = 2;
    expect_rd(3, 8'h2A, 8'h5C);
    consumer_read_address[3] = 8'h2A;
    consumer_read_valid[3]   = 1'b1;
    @(negedge clk);
    consumer_read_address[3] = 8'hFF;
    @(negedge clk);
    check("t1_cache_addr", 32'(cache_read_address), 32'h2A);
    wait_read_ready("t1_ready", 3);
    check("t1_ready_vec", 32'(consumer_read_ready), 32'h08);
    check("t1_grant_id", 32'(grant_id), 32'd3);
    check("t1_rd_data", 32'(consumer_read_data[3]), 32'h5C);
    consumer_read_valid[3] = 1'b0;
    wait_idle();
    check("t1_grant_hold", 32'(grant_id), 32'd3);

    // 2: two all-consumer bursts, each served 0..7
    reset_dut();
    cache_lat = 1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        expect_rd(i, 8'(64 + 16 * b + i), mem_rd(8'(64 + 16 * b + i)));
      end
      lsu_done = 0;
      for (int i = 0; i < N; i++) begin
        fork
          automatic int         c = i;
          automatic logic [7:0] a = 8'(64 + 16 * b + i);
          lsu_read(c, a, 0);
        join_none
      end
      wait_done("t2_burst_done", N);
      wait_idle();
    end

    // 3: consumers 1 and 5 re-request continuously, grants alternate
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      expect_rd(1, 8'(8'h10 + k), mem_rd(8'(8'h10 + k)));
      expect_rd(5, 8'(8'h50 + k), mem_rd(8'(8'h50 + k)));
    end
    lsu_done = 0;
    fork
      begin
        for (int k = 0; k < 3; k++) lsu_read(1, 8'(8'h10 + k), 0);
      end
      begin
        for (int k = 0; k < 3; k++) lsu_read(5, 8'(8'h50 + k), 0);
      end
    join_none
    wait_done("t3_done", 6);
    wait_idle();

    // 4: consumer 2 read+write together, consumer 3 write in between
    reset_dut();
    cache_lat = 2;
    expect_rd(2, 8'h10, 8'h66);
    expect_wr(3, 8'h33, 8'hC3);
    expect_wr(2, 8'h11, 8'hAB);
    lsu_done = 0;
    fork
      lsu_read(2, 8'h10, 0);
      lsu_write(2, 8'h11, 8'hAB, 0);
      lsu_write(3, 8'h33, 8'hC3, 0);
    join_none
    wait_done("t4_done", 3);
    wait_idle();

    // 5: slow release by consumer 0 holds off consumer 1
    reset_dut();
    cache_lat = 1;
    expect_rd(0, 8'h70, 8'h06);
    expect_rd(1, 8'h71, 8'h07);
    lsu_done = 0;
    fork
      lsu_read(0, 8'h70, 4);
      lsu_read(1, 8'h71, 0);
      begin
        wait_read_ready("t5_ready0", 0);
        repeat (3) begin
          @(negedge clk);
          check("t5_busy", 32'(busy), 32'd1);
          check("t5_no_new_req", 32'({cache_read_valid, grant_id}), 32'd0);
        end
      end
    join_none
    wait_done("t5_done", 2);
    wait_idle();

    // 6: async reset during READ_WAIT, then search restarts from 0
    expect_rd(5, 8'h55, 8'h23);
    lsu_done = 0;
    lsu_read(5, 8'h55, 0);
    wait_idle();
    cache_lat = 20;
    req_q.push_back(mk(5, 1'b0, 8'h99, 8'h00));
    consumer_read_address[5] = 8'h99;
    consumer_read_valid[5]   = 1'b1;
    cnt = 0;
    while (!cache_read_valid && cnt < TMO) begin @(negedge clk); cnt++; end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_rd_valid", 32'(cache_read_valid), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_grant", 32'(grant_id), 32'd0);
    check("t6_async_rd_data5", 32'(consumer_read_data[5]), 32'd0);
    consumer_read_valid[5]   = 1'b0;
    consumer_read_address[4] = 8'h44;
    consumer_read_address[7] = 8'h77;
    consumer_read_valid[4]   = 1'b1;
    consumer_read_valid[7]   = 1'b1;
    cache_lat = 1;
    expect_rd(4, 8'h44, 8'h32);
    expect_rd(7, 8'h77, 8'h01);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    while (!consumer_read_ready[4] && cnt < TMO) begin @(negedge clk); cnt++; end
    check("t6_latency", 32'(cnt), 32'd2);
    check("t6_grant_id", 32'(grant_id), 32'd4);
    consumer_read_valid[4] = 1'b0;
    wait_read_ready("t6_ready7", 7);
    consumer_read_valid[7] = 1'b0;
    wait_idle();

    check("req_q_left", 32'(req_q.size()), 32'd0);
    check("rsp_q_left", 32'(rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
